// File: rtl/hdr_dispatch_if.sv
// Command/engine bundle between the i3c engine, hdr_dispatch and its sub-engines.
// slave = dispatcher view, master = driver (i3c engine / bench) view.
interface hdr_dispatch_if #(
  parameter int NUM_ENG = 3,
  parameter int ADDR_W  = 12
);
  localparam int SEL_W = $clog2(NUM_ENG);

  logic               i_hdr_en;
  logic               i_cmd_valid;
  logic [SEL_W-1:0]   i_cmd_sel;
  logic               i_cmd_toc;
  logic [2:0]         i_mode;
  logic [NUM_ENG-1:0] i_eng_done;
  logic               o_cmd_ready;
  logic [NUM_ENG-1:0] o_eng_en;
  logic [ADDR_W-1:0]  o_regf_addr_special;
  logic               o_hdr_done;
  logic [1:0]         o_err_code;
  logic               o_busy;

  modport slave (
    input  i_hdr_en, i_cmd_valid, i_cmd_sel, i_cmd_toc, i_mode, i_eng_done,
    output o_cmd_ready, o_eng_en, o_regf_addr_special, o_hdr_done, o_err_code, o_busy
  );

  modport master (
    output i_hdr_en, i_cmd_valid, i_cmd_sel, i_cmd_toc, i_mode, i_eng_done,
    input  o_cmd_ready, o_eng_en, o_regf_addr_special, o_hdr_done, o_err_code, o_busy
  );
endinterface

// File: rtl/hdr_dispatch.sv
// HDR command dispatcher: routes each accepted command to one sub-engine,
// inserts a dummy pass on engine 0 when leaving a CCC for another engine,
// and reports completion status with a one-cycle done pulse.
module hdr_dispatch #(
  parameter int NUM_ENG    = 3,
  parameter int ADDR_W     = 12,
  parameter int IDLE_ADDR  = 1000,
  parameter int DUMMY_ADDR = 450,
  parameter int HDR_MODE   = 6,
  parameter int TO_CYC     = 255
) (
  input logic           i_sys_clk,
  input logic           i_sys_rst_n,
  hdr_dispatch_if.slave bus
);
  localparam int SEL_W   = $clog2(NUM_ENG);
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam int TO_M1   = TO_CYC - 1;

  localparam logic [SEL_W:0]       ENG_LIM = NUM_ENG[SEL_W:0];
  localparam logic [2:0]           MODE_L  = HDR_MODE[2:0];
  localparam logic [ADDR_W-1:0]    A_IDLE  = IDLE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0]    A_DUMMY = DUMMY_ADDR[ADDR_W-1:0];
  localparam logic [TO_W-1:0]      TO_LAST = TO_M1[TO_W-1:0];
  localparam logic [TO_W-1:0]      TO_MAX  = TO_CYC[TO_W-1:0];
  localparam logic [NUM_ENG-1:0]   ONE     = {{(NUM_ENG-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT_NEXT, S_DUMMY, S_EXIT} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   cur_sel, sel_nxt;
  logic               cur_toc, toc_nxt;
  logic [TO_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [NUM_ENG-1:0] eng_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               done_nxt;
  logic [1:0]         err_nxt;
  logic               exit_req;
  logic [1:0]         exit_code;
  logic               mode_bad, accept, sel_ok, done_cur, done_zero, to_hit;

  function automatic logic [NUM_ENG-1:0] onehot(input logic [SEL_W-1:0] s);
    return ONE << s;
  endfunction

  assign mode_bad  = (bus.i_mode != MODE_L);
  assign bus.o_cmd_ready = ((state == S_IDLE) || (state == S_WAIT_NEXT)) &&
                           bus.i_hdr_en && !mode_bad;
  assign bus.o_busy = (state != S_IDLE);
  assign accept    = bus.i_cmd_valid && bus.o_cmd_ready;
  assign sel_ok    = ({1'b0, bus.i_cmd_sel} < ENG_LIM);
  // Only the engine currently owning the bus may complete it.
  assign done_cur  = |(bus.i_eng_done & onehot(cur_sel));
  assign done_zero = bus.i_eng_done[0];
  assign to_hit    = (cnt >= TO_LAST);
  // Saturating increment so a stuck counter can never wrap back below the limit.
  assign cnt_inc   = (cnt == TO_MAX) ? cnt : cnt + 1'b1;

  // Next-state and next-output decode; exit paths funnel through exit_req.
  always_comb begin
    state_nxt = state;
    sel_nxt   = cur_sel;
    toc_nxt   = cur_toc;
    cnt_nxt   = cnt;
    eng_nxt   = bus.o_eng_en;
    addr_nxt  = bus.o_regf_addr_special;
    done_nxt  = 1'b0;
    err_nxt   = bus.o_err_code;
    exit_req  = 1'b0;
    exit_code = 2'd0;
    if (!bus.i_hdr_en) begin
      state_nxt = S_IDLE;
      eng_nxt   = '0;
      addr_nxt  = A_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE, S_WAIT_NEXT: begin
          if (state == S_WAIT_NEXT && mode_bad) begin
            exit_req  = 1'b1;
            exit_code = 2'd2;
          end else if (accept) begin
            sel_nxt = bus.i_cmd_sel;
            toc_nxt = bus.i_cmd_toc;
            if (!sel_ok) begin
              exit_req  = 1'b1;
              exit_code = 2'd3;
            end else if (state == S_WAIT_NEXT && cur_sel == '0 && bus.i_cmd_sel != '0) begin
              // Leaving the CCC engine: flush with a dummy pass on engine 0 first.
              state_nxt = S_DUMMY;
              eng_nxt   = ONE;
              addr_nxt  = A_DUMMY;
              cnt_nxt   = '0;
            end else begin
              state_nxt = S_RUN;
              eng_nxt   = onehot(bus.i_cmd_sel);
              cnt_nxt   = '0;
            end
          end
        end
        S_RUN: begin
          if (mode_bad) begin
            exit_req  = 1'b1;
            exit_code = 2'd2;
          end else if (done_cur) begin
            if (cur_toc) begin
              exit_req  = 1'b1;
              exit_code = 2'd0;
            end else begin
              state_nxt = S_WAIT_NEXT;
              eng_nxt   = '0;
            end
          end else if (to_hit) begin
            exit_req  = 1'b1;
            exit_code = 2'd1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_DUMMY: begin
          if (mode_bad) begin
            exit_req  = 1'b1;
            exit_code = 2'd2;
          end else if (done_zero) begin
            state_nxt = S_RUN;
            eng_nxt   = onehot(cur_sel);
            addr_nxt  = A_IDLE;
            cnt_nxt   = '0;
          end else if (to_hit) begin
            exit_req  = 1'b1;
            exit_code = 2'd1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_EXIT:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
      if (exit_req) begin
        state_nxt = S_EXIT;
        done_nxt  = 1'b1;
        err_nxt   = exit_code;
        eng_nxt   = '0;
        addr_nxt  = A_IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state                   <= S_IDLE;
      cur_sel                 <= '0;
      cur_toc                 <= 1'b0;
      cnt                     <= '0;
      bus.o_eng_en            <= '0;
      bus.o_regf_addr_special <= A_IDLE;
      bus.o_hdr_done          <= 1'b0;
      bus.o_err_code          <= 2'd0;
    end else begin
      state                   <= state_nxt;
      cur_sel                 <= sel_nxt;
      cur_toc                 <= toc_nxt;
      cnt                     <= cnt_nxt;
      bus.o_eng_en            <= eng_nxt;
      bus.o_regf_addr_special <= addr_nxt;
      bus.o_hdr_done          <= done_nxt;
      bus.o_err_code          <= err_nxt;
    end
  end
endmodule

// File: tb/tb_hdr_dispatch.sv
// Bench for hdr_dispatch: job-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hdr_dispatch;
  localparam int NE = 3;
  localparam int AW = 12;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hdr_dispatch_if #(.NUM_ENG(NE), .ADDR_W(AW)) bus ();

  hdr_dispatch #(.NUM_ENG(NE), .ADDR_W(AW), .TO_CYC(TO)) dut (
    .i_sys_clk  (clk),
    .i_sys_rst_n(rst_n),
    .bus        (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: which engine is driven, which engine waits behind a
  // dummy pass, how long the current job has run, and any pending exit code.
  typedef struct packed {
    int active;   // engine enabled, -1 none
    int pending;  // engine to start after dummy pass, -1 none
    int exit_c;   // completion code being reported, -1 none
    int age;      // cycles spent in the current job
    int prev;     // last accepted select
    bit waiting;  // between chained commands
    bit toc;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t m_reset();
    mdl_t r;
    r.active = -1; r.pending = -1; r.exit_c = -1; r.age = 0;
    r.prev = 0; r.waiting = 1'b0; r.toc = 1'b0;
    return r;
  endfunction

  function automatic bit m_busy(input mdl_t s);
    return (s.active >= 0) || s.waiting || (s.exit_c >= 0);
  endfunction

  function automatic bit m_ready(input mdl_t s, input bit en, input int mode);
    return (!m_busy(s) || s.waiting) && en && (mode == 6);
  endfunction

  function automatic mdl_t m_exit(input mdl_t s, input int code);
    mdl_t r = s;
    r.active = -1; r.pending = -1; r.waiting = 1'b0; r.exit_c = code; r.age = 0;
    return r;
  endfunction

  function automatic mdl_t m_step(input mdl_t s, input bit en, input bit valid,
                                  input int sel, input bit toc, input int mode,
                                  input logic [NE-1:0] done);
    mdl_t r = s;
    if (!en) return m_reset_keep(s);
    if (s.exit_c >= 0) begin
      r.exit_c = -1;
    end else if (s.active >= 0) begin
      if (mode != 6) r = m_exit(s, 2);
      else if (done[s.active]) begin
        if (s.pending >= 0) begin
          r.active = s.pending; r.pending = -1; r.age = 0;
        end else if (s.toc) r = m_exit(s, 0);
        else begin
          r.active = -1; r.waiting = 1'b1;
        end
      end else if (s.age >= TO - 1) r = m_exit(s, 1);
      else r.age = (s.age + 1 > TO) ? TO : s.age + 1;
    end else if (s.waiting && mode != 6) begin
      r = m_exit(s, 2);
    end else if (valid && m_ready(s, en, mode)) begin
      r.prev = sel; r.toc = toc; r.waiting = 1'b0; r.age = 0;
      if (sel >= NE) r = m_exit(r, 3);
      else if (s.waiting && s.prev == 0 && sel != 0) begin
        r.active = 0; r.pending = sel;
      end else r.active = sel;
    end
    return r;
  endfunction

  // Disable drops everything but keeps the last select/termination flag.
  function automatic mdl_t m_reset_keep(input mdl_t s);
    mdl_t r = m_reset();
    r.prev = s.prev; r.toc = s.toc;
    return r;
  endfunction

  // Advance the model on every active edge; reset clears it immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else m <= m_step(m, bus.i_hdr_en, bus.i_cmd_valid, int'(bus.i_cmd_sel),
                     bus.i_cmd_toc, int'(bus.i_mode), bus.i_eng_done);
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    chk("eng_en", int'(bus.o_eng_en), (m.active >= 0) ? (1 << m.active) : 0);
    chk("addr", int'(bus.o_regf_addr_special), (m.pending >= 0) ? 450 : 1000);
    chk("hdr_done", int'(bus.o_hdr_done), int'(m.exit_c >= 0));
    chk("busy", int'(bus.o_busy), int'(m_busy(m)));
    chk("cmd_ready", int'(bus.o_cmd_ready),
        int'(m_ready(m, bus.i_hdr_en, int'(bus.i_mode))));
    if (m.exit_c >= 0) chk("err_code", int'(bus.o_err_code), m.exit_c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input bit toc);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_sel   = sel;
    bus.i_cmd_toc   = toc;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic pulse(input logic [NE-1:0] d);
    bus.i_eng_done = d;
    tick();
    bus.i_eng_done = '0;
  endtask

  initial begin
    int n;
    int seen;
    bus.i_hdr_en    = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_sel   = '0;
    bus.i_cmd_toc   = 1'b0;
    bus.i_mode      = 3'd6;
    bus.i_eng_done  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_eng_en", int'(bus.o_eng_en), 0);
    chk("rst_addr", int'(bus.o_regf_addr_special), 1000);
    chk("rst_done", int'(bus.o_hdr_done), 0);
    chk("rst_err", int'(bus.o_err_code), 0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.o_cmd_ready), 1);

    // Single command on engine 1, done five cycles after acceptance
    send(2'd1, 1'b1);
    @(negedge clk);
    chk("t1_eng_en", int'(bus.o_eng_en), 3'b010);
    repeat (4) tick();
    pulse(3'b010);
    @(negedge clk);
    chk("t1_done", int'(bus.o_hdr_done), 1);
    chk("t1_err", int'(bus.o_err_code), 0);
    tick();
    @(negedge clk);
    chk("t1_busy", int'(bus.o_busy), 0);

    // CCC then engine 1: dummy pass inserted in between
    send(2'd0, 1'b0);
    tick();
    pulse(3'b001);
    send(2'd1, 1'b1);
    @(negedge clk);
    chk("t2_dummy_en", int'(bus.o_eng_en), 3'b001);
    chk("t2_dummy_addr", int'(bus.o_regf_addr_special), 450);
    pulse(3'b001);
    @(negedge clk);
    chk("t2_run_en", int'(bus.o_eng_en), 3'b010);
    chk("t2_run_addr", int'(bus.o_regf_addr_special), 1000);
    pulse(3'b010);
    @(negedge clk);
    chk("t2_done", int'(bus.o_hdr_done), 1);
    chk("t2_err", int'(bus.o_err_code), 0);
    tick();

    // Timeout: engine 2 never answers
    send(2'd2, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.o_hdr_done && n < TO + 10) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("t3_timeout_lat", n, TO);
    chk("t3_err", int'(bus.o_err_code), 1);
    tick();

    // Mode abort while running
    send(2'd1, 1'b1);
    tick(); tick();
    bus.i_mode = 3'd3;
    tick();
    @(negedge clk);
    chk("t4_done", int'(bus.o_hdr_done), 1);
    chk("t4_err", int'(bus.o_err_code), 2);
    chk("t4_eng_en", int'(bus.o_eng_en), 0);
    bus.i_mode = 3'd6;
    tick();

    // Bad select
    send(2'd3, 1'b1);
    @(negedge clk);
    chk("t5_done", int'(bus.o_hdr_done), 1);
    chk("t5_err", int'(bus.o_err_code), 3);
    chk("t5_eng_en", int'(bus.o_eng_en), 0);
    tick();

    // Disable mid-command: silent drop
    send(2'd2, 1'b1);
    tick();
    bus.i_hdr_en = 1'b0;
    tick();
    bus.i_hdr_en = 1'b1;
    @(negedge clk);
    chk("t6_busy", int'(bus.o_busy), 0);
    chk("t6_eng_en", int'(bus.o_eng_en), 0);
    chk("t6_done", int'(bus.o_hdr_done), 0);

    // Reset while in the dummy pass
    send(2'd0, 1'b0);
    pulse(3'b001);
    send(2'd2, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_eng_en", int'(bus.o_eng_en), 0);
    chk("t7_addr", int'(bus.o_regf_addr_special), 1000);
    chk("t7_done", int'(bus.o_hdr_done), 0);
    chk("t7_busy", int'(bus.o_busy), 0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (bus.o_hdr_done) seen++;
    end
    chk("t7_no_done", seen, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.i_cmd_valid = ($urandom_range(0, 2) == 0);
      bus.i_cmd_sel   = 2'($urandom_range(0, 3));
      bus.i_cmd_toc   = 1'($urandom_range(0, 1));
      bus.i_mode      = ($urandom_range(0, 59) == 0) ? 3'd3 : 3'd6;
      bus.i_hdr_en    = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 9))
        0, 1:    bus.i_eng_done = 3'(1 << $urandom_range(0, 2));
        2:       bus.i_eng_done = 3'($urandom_range(0, 7));
        default: bus.i_eng_done = '0;
      endcase
    end
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_eng_done  = '0;
    bus.i_mode      = 3'd6;
    bus.i_hdr_en    = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hdr_dispatch.md
HDR_DISPATCH -- requirements
Module: hdr_dispatch

Interface
REQ-001 Parameter NUM_ENG, default 3: number of sub-engines, from 2 to 8; index 0 is the CCC engine and index 1 is the DDR engine.
REQ-002 Parameter ADDR_W, default 12: width of the special register-file address.
REQ-003 Parameter IDLE_ADDR, default 1000: address driven on o_regf_addr_special when no dummy pass is active.
REQ-004 Parameter DUMMY_ADDR, default 450: address of the dummy-value location in the register file.
REQ-005 Parameter HDR_MODE, default 6: value of i_mode that keeps the block in HDR operation.
REQ-006 Parameter TO_CYC, default 255: engine timeout in cycles; TO_W = clog2(TO_CYC+1).
REQ-007 i_sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-008 i_sys_rst_n  in  1  asynchronous active-low reset.
REQ-009 i_hdr_en  in  1  block enable from the i3c engine.
REQ-010 i_cmd_valid  in  1  a command descriptor is present.
REQ-011 i_cmd_sel  in  SEL_W=clog2(NUM_ENG)  target engine index.
REQ-012 i_cmd_toc  in  1  termination of completion: 1 means exit after this command, 0 means restart.
REQ-013 i_mode  in  3  current bus mode.
REQ-014 i_eng_done  in  NUM_ENG  per-engine single-cycle done pulses.
REQ-015 o_cmd_ready  out  1  the block can accept a command this cycle.
REQ-016 o_eng_en  out  NUM_ENG  one-hot or zero engine enable, registered.
REQ-017 o_regf_addr_special  out  ADDR_W  special register-file address, registered.
REQ-018 o_hdr_done  out  1  single-cycle completion pulse.
REQ-019 o_err_code  out  2  completion status, valid only while o_hdr_done=1: 0 ok, 1 timeout, 2 mode abort, 3 bad select.
REQ-020 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 The block SHALL implement the states IDLE, RUN, WAIT_NEXT, DUMMY and EXIT.
REQ-022 A command SHALL be accepted on a cycle where i_cmd_valid=1, o_cmd_ready=1 and i_hdr_en=1; on acceptance the block latches sel and toc.
REQ-023 o_cmd_ready SHALL be combinational and equal 1 only in IDLE or WAIT_NEXT, with i_hdr_en=1 and i_mode=HDR_MODE.
REQ-024 IDLE->RUN on acceptance; o_eng_en[sel] SHALL rise in the cycle after acceptance, giving a 1-cycle latency.
REQ-025 In RUN, only i_eng_done[cur_sel] SHALL be honoured; done pulses from any other engine are ignored.
REQ-026 RUN on done: if toc=1 the block goes to EXIT with code 0; if toc=0 it goes to WAIT_NEXT. o_eng_en SHALL clear in the cycle after the done.
REQ-027 WAIT_NEXT on acceptance: if the previous sel=0 and the new sel!=0, the block goes to DUMMY; otherwise it goes to RUN with the new sel.
REQ-028 DUMMY: o_eng_en[0]=1 and o_regf_addr_special=DUMMY_ADDR; on i_eng_done[0] the block goes to RUN with the pending sel and the address returns to IDLE_ADDR.
REQ-029 EXIT: o_hdr_done=1 for exactly 1 cycle with o_err_code valid and o_eng_en=0, then the block goes to IDLE.
REQ-030 An accepted sel>=NUM_ENG SHALL go directly to EXIT with code 3 and no engine enabled.
REQ-031 A timeout counter SHALL clear on entry to RUN or DUMMY and increment each cycle in those states; at TO_CYC-1 the block goes to EXIT with code 1. The counter SHALL saturate and never wrap.
REQ-032 i_mode!=HDR_MODE in RUN, WAIT_NEXT or DUMMY SHALL send the block to EXIT with code 2 on the next edge.
REQ-033 Simultaneous events SHALL resolve with priority mode abort > engine done > timeout; a done coinciding with the timeout cycle counts as normal completion.
REQ-034 i_hdr_en=0 SHALL synchronously force IDLE, clear o_eng_en, o_hdr_done and the counter, and set the address to IDLE_ADDR, with no done pulse.
REQ-035 At most one bit of o_eng_en SHALL be high at any time.

Reset
REQ-036 Asserting i_sys_rst_n low SHALL immediately set the state to IDLE, o_eng_en=0, o_hdr_done=0, o_err_code=0, o_regf_addr_special=IDLE_ADDR, the counter to 0 and the latched sel/toc to 0.
REQ-037 Reset asserted mid-command SHALL abort the command silently, with no o_hdr_done pulse after release.
REQ-038 After reset release, o_cmd_ready SHALL be asserted in the first cycle in which i_hdr_en=1 and i_mode=6.

Verification
REQ-039 Accept sel=1 toc=1, pulse i_eng_done[1] 5 cycles later -> o_eng_en=3'b010 one cycle after acceptance, then o_hdr_done=1 with o_err_code=0, then o_busy=0.
REQ-040 Accept sel=0 toc=0 and complete it, then accept sel=1 toc=1 -> DUMMY with o_eng_en=3'b001 and addr=450; after done[0], o_eng_en=3'b010 and addr=1000; after done[1], done pulse with code 0.
REQ-041 Accept sel=2, never return done -> o_hdr_done with code 1 exactly TO_CYC cycles after RUN entry.
REQ-042 Accept sel=1, drive i_mode=3 while in RUN -> done pulse with code 2 on the next cycle and o_eng_en=0.
REQ-043 With NUM_ENG=3, accept sel=3 -> done pulse with code 3 and o_eng_en never set.
REQ-044 Assert i_sys_rst_n low while in DUMMY -> outputs immediately at reset values, and no done pulse after release.
